// File: rtl/md_unit.sv
// md_unit - E-stage multiply/divide unit holding the architectural HI/LO pair.
//
// Long ops (mult, multu, div, divu) compute their 64-bit result on the start
// edge into temporaries. The unit then stays busy for MULT_CYCLES or
// DIV_CYCLES cycles, and commits the temporaries to HI/LO when the count
// expires. mthi/mtlo write in a single cycle. mfhi/mflo read through md_out.
//
// Optional feature macro: MD_MADD_EN. When defined, md_op codes 9..12 are
// madd/maddu/msub/msubu. When undefined, those codes are no-ops.
//
// Ports:
//   clk     in   1   clock, rising edge
//   reset   in   1   asynchronous active-high reset
//   start   in   1   md op present in E this cycle (qualifies md_op)
//   md_op   in   4   operation code
//   rs_val  in  32   forwarded rs operand
//   rt_val  in  32   forwarded rt operand
//   busy    out  1   long operation in flight
//   hi      out 32   HI register
//   lo      out 32   LO register
//   md_out  out 32   hi for mfhi, lo for mflo, else 0 (combinational)

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    logic        r_state;
    logic        r_busy;
    logic [31:0] r_cnt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_tmp_hi, r_tmp_lo;

    // Products
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    assign w_prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divides. A zero divisor is replaced by 1 so the dividers never produce
    // X. The result is discarded in that case anyway.
    logic [31:0] w_abs_rs, w_abs_rt, w_sden, w_uden;
    logic [31:0] w_sq, w_sr, w_uq, w_ur;
    logic [31:0] w_div_q, w_div_r;
    assign w_abs_rs = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign w_abs_rt = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign w_sden   = (w_abs_rt == 32'd0) ? 32'd1 : w_abs_rt;
    assign w_uden   = (rt_val == 32'd0) ? 32'd1 : rt_val;
    assign w_sq     = w_abs_rs / w_sden;
    assign w_sr     = w_abs_rs % w_sden;
    assign w_uq     = rs_val / w_uden;
    assign w_ur     = rs_val % w_uden;
    // Quotient truncates toward zero. The remainder follows the dividend's
    // sign. 0x80000000 / -1 wraps back to 0x80000000 through the magnitude
    // path.
    assign w_div_q  = (rs_val[31] ^ rt_val[31]) ? (~w_sq + 32'd1) : w_sq;
    assign w_div_r  = rs_val[31] ? (~w_sr + 32'd1) : w_sr;

    // Decode the long op and its result
    logic        w_long;
    logic [31:0] w_len;
    logic [63:0] w_res;

    always_comb begin
        w_long = 1'b0;
        w_len  = 32'(MULT_CYCLES);
        w_res  = {r_hi, r_lo};
        case (md_op)
            4'd1: begin w_long = 1'b1; w_res = w_prod_s; end
            4'd2: begin w_long = 1'b1; w_res = w_prod_u; end
            4'd3: begin
                w_long = 1'b1;
                w_len  = 32'(DIV_CYCLES);
                // Divide by zero commits the current HI/LO, leaving them unchanged.
                if (rt_val != 32'd0) w_res = {w_div_r, w_div_q};
            end
            4'd4: begin
                w_long = 1'b1;
                w_len  = 32'(DIV_CYCLES);
                if (rt_val != 32'd0) w_res = {w_ur, w_uq};
            end
`ifdef MD_MADD_EN
            4'd9:  begin w_long = 1'b1; w_res = {r_hi, r_lo} + w_prod_s; end
            4'd10: begin w_long = 1'b1; w_res = {r_hi, r_lo} + w_prod_u; end
            4'd11: begin w_long = 1'b1; w_res = {r_hi, r_lo} - w_prod_s; end
            4'd12: begin w_long = 1'b1; w_res = {r_hi, r_lo} - w_prod_u; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_long) begin
                            r_tmp_hi <= w_res[63:32];
                            r_tmp_lo <= w_res[31:0];
                            r_cnt    <= w_len;
                            r_busy   <= 1'b1;
                            r_state  <= S_BUSY;
                        end else if (md_op == 4'd5) begin
                            r_hi <= rs_val;
                        end else if (md_op == 4'd6) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                default: begin
                    // start is ignored while busy
                    if (r_cnt == 32'd1) begin
                        r_hi    <= r_tmp_hi;
                        r_lo    <= r_tmp_lo;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    r_cnt <= r_cnt - 32'd1;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign md_out = (md_op == 4'd7) ? r_hi :
                    (md_op == 4'd8) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hi, lo, md_out;

    int total = 0;
    int bad   = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
        .hi(hi), .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    // Present one op for one edge; returns at the negedge after that edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        md_op = 4'd0;
    endtask

    // Counts negedges with busy high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; md_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
        @(negedge clk); @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int n;
        issue(4'd1, 32'hFFFF_FFFD, 32'd5);
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL mult_hi_early got=%h exp=0", hi); end
        wait_idle(n);
        total++; if (n !== 5) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
    endtask

    task automatic test_divu;
        int n;
        issue(4'd4, 32'd100, 32'd7);
        rs_val = 32'd55; rt_val = 32'd3;
        wait_idle(n);
        total++; if (n !== 10) begin bad++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%0d exp=14", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%0d exp=2", hi); end
    endtask

    task automatic test_div_neg;
        int n;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL divneg_lo got=%h exp=fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divneg_hi got=%h exp=ffffffff", hi); end
    endtask

    task automatic test_div_zero;
        int n;
        issue(4'd5, 32'h1234, 32'd0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
        issue(4'd6, 32'h5678, 32'd0);
        issue(4'd3, 32'd99, 32'd0);
        wait_idle(n);
        total++; if (n !== 10) begin bad++; $display("FAIL divz_busy_cycles got=%0d exp=10", n); end
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL divz_hi got=%h exp=1234", hi); end
        total++; if (lo !== 32'h5678) begin bad++; $display("FAIL divz_lo got=%h exp=5678", lo); end
    endtask

    task automatic test_div_ovf;
        int n;
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL divovf_hi got=%h exp=0", hi); end
    endtask

    task automatic test_busy_ignore;
        int n;
        issue(4'd1, 32'h0001_0000, 32'h0003_0000);
        @(negedge clk);
        issue(4'd5, 32'hDEAD, 32'd0);
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL ign_hi_mid got=%h exp=0", hi); end
        wait_idle(n);
        total++; if (hi !== 32'd3) begin bad++; $display("FAIL ign_hi got=%h exp=3", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL ign_lo got=%h exp=0", lo); end
    endtask

    task automatic test_reset_mid;
        issue(4'd3, 32'd100, 32'd7);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL rstmid_late got=%h_%h exp=0_0", hi, lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_late_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_mfhi_mflo;
        issue(4'd5, 32'hAAAA, 32'd0);
        issue(4'd6, 32'hBBBB, 32'd0);
        md_op = 4'd8; #1;
        total++; if (md_out !== 32'hBBBB) begin bad++; $display("FAIL mflo got=%h exp=bbbb", md_out); end
        md_op = 4'd7; #1;
        total++; if (md_out !== 32'hAAAA) begin bad++; $display("FAIL mfhi got=%h exp=aaaa", md_out); end
        md_op = 4'd3; #1;
        total++; if (md_out !== 32'd0) begin bad++; $display("FAIL mdout_other got=%h exp=0", md_out); end
        md_op = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_madd;
        int n;
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'd10, 32'd0);
        issue(4'd9, 32'd3, 32'd4);
`ifdef MD_MADD_EN
        wait_idle(n);
        total++; if (n !== 5) begin bad++; $display("FAIL madd_busy_cycles got=%0d exp=5", n); end
        total++; if (lo !== 32'd22) begin bad++; $display("FAIL madd_lo got=%0d exp=22", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL madd_hi got=%h exp=0", hi); end
`else
        n = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL op9_busy got=%0b exp=0", busy); end
        repeat (6) @(negedge clk);
        total++; if (lo !== 32'd10) begin bad++; $display("FAIL op9_lo got=%0d exp=10", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL op9_hi got=%h exp=0", hi); end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mult();
        test_divu();
        test_div_neg();
        test_div_zero();
        test_div_ovf();
        test_busy_ignore();
        test_reset_mid();
        test_mfhi_mflo();
        test_madd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
